// File: rtl/lcd_num_formatter_pkg.sv
// lcd_pkg: shared constants for the 2x16 text LCD path (ASCII codes,
// panel geometry) and the formatter FSM state encoding.
// Optional feature macro used by the formatter: LCD_FMT_HEX_EN.
package lcd_pkg;

   localparam int LCD_COLS  = 16;
   localparam int LCD_LINES = 2;

   localparam logic [7:0] SPACE   = 8'h20;
   localparam logic [7:0] MINUS   = 8'h2D;
   localparam logic [7:0] ZERO    = 8'h30;
   localparam logic [7:0] ALPHA_A = 8'h41;

   typedef enum logic [2:0] {
      IDLE,
      ABS,
      CONVERT,
      WRITE,
      DONE
   } fmt_state_t;

   // Uppercase ASCII for one hex nibble.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (ZERO + {4'd0, nib}) : (ALPHA_A + {4'd0, nib} - 8'd10);
   endfunction

endpackage

// File: rtl/lcd_num_formatter_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one input bit per clock.
// The MSB of bin is preloaded into the BCD register so only DATA_W shift
// cycles are needed for a DATA_W+1 bit magnitude.
module bin2bcd_seq #(
   parameter int DATA_W = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W:0]       bin,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd
);

   localparam int CNTW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [DATA_W-1:0]   sh_reg;
   logic [DIGITS*4-1:0] bcd_reg;
   logic [DIGITS*4-1:0] adj;
   logic                run_reg;
   logic [CNTW-1:0]     cnt_reg;

   // Add-3 correction on every nibble that would overflow past 9 when doubled.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                 (bcd_reg[gi*4 +: 4] + 4'd3) : bcd_reg[gi*4 +: 4];
      end
   endgenerate

   // Load on start, then shift one bit per cycle for DATA_W cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_reg  <= '0;
         bcd_reg <= '0;
         run_reg <= 1'b0;
         cnt_reg <= '0;
      end else if (start) begin
         sh_reg  <= bin[DATA_W-1:0];
         bcd_reg <= {{(DIGITS*4-1){1'b0}}, bin[DATA_W]};
         run_reg <= 1'b1;
         cnt_reg <= '0;
      end else if (run_reg) begin
         {bcd_reg, sh_reg} <= {adj, sh_reg} << 1;
         cnt_reg           <= cnt_reg + CNTW'(1);
         if (cnt_reg == CNTW'(DATA_W-1)) begin
            run_reg <= 1'b0;
         end
      end
   end

   // High during the final shift cycle; bcd is complete on the next cycle.
   assign done = run_reg && (cnt_reg == CNTW'(DATA_W-1));
   assign bcd  = bcd_reg;

endmodule

// File: rtl/lcd_num_formatter.sv
// lcd_num_formatter: converts a signed value to right-justified decimal
// ASCII and writes it into one line of a 2x16 character buffer that the
// LCD driver reads by line/column.
// Optional: define LCD_FMT_HEX_EN to add in_hex (unsigned hex display).
module lcd_num_formatter
   import lcd_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DIGITS = 5,
   parameter int COLS   = LCD_COLS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_line,
`ifdef LCD_FMT_HEX_EN
   input  logic              in_hex,
`endif
   input  logic              rd_line,
   input  logic [3:0]        rd_col,
   output logic [7:0]        rd_char,
   output logic              busy,
   output logic              frame_upd
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   fmt_state_t          state_reg, state_next;
   logic [DATA_W-1:0]   data_reg;
   logic                line_reg;
   logic                neg_reg;
   logic [CW-1:0]       col_reg;
   logic [DATA_W:0]     sext;
   logic [DATA_W:0]     mag;
   logic                accept;
   logic                bcd_start;
   logic                bcd_done;
   logic [DIGITS*4-1:0] bcd;
   int                  ndig;
   int                  k;
   logic [3:0]          dig;
   logic [7:0]          char_next;
   logic [7:0]          buf_reg [LCD_LINES][COLS];
   logic [7:0]          rd_char_reg;
`ifdef LCD_FMT_HEX_EN
   localparam int HEX_DIGITS = DATA_W / 4;
   logic                hex_reg;
   logic [3:0]          nib;
`endif

   assign accept    = in_valid && in_ready;
   assign sext      = {data_reg[DATA_W-1], data_reg};
   assign mag       = data_reg[DATA_W-1] ? -sext : sext;
`ifdef LCD_FMT_HEX_EN
   assign bcd_start = (state_reg == ABS) && !hex_reg;
`else
   assign bcd_start = (state_reg == ABS);
`endif

   bin2bcd_seq #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (bcd_start),
      .bin   (mag),
      .done  (bcd_done),
      .bcd   (bcd)
   );

   // State register, latched request and column counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         line_reg  <= 1'b0;
         neg_reg   <= 1'b0;
         col_reg   <= '0;
`ifdef LCD_FMT_HEX_EN
         hex_reg   <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         if (accept) begin
            data_reg <= in_data;
            line_reg <= in_line;
`ifdef LCD_FMT_HEX_EN
            hex_reg  <= in_hex;
`endif
         end
         if (state_reg == ABS) begin
            neg_reg <= data_reg[DATA_W-1];
         end
         col_reg <= (state_reg == WRITE) ? (col_reg + CW'(1)) : '0;
      end
   end

   // Next-state logic and status outputs.
   always_comb begin
      state_next = state_reg;
      in_ready   = (state_reg == IDLE);
      busy       = (state_reg != IDLE);
      frame_upd  = (state_reg == DONE);
      case (state_reg)
         IDLE:    if (in_valid) state_next = ABS;
`ifdef LCD_FMT_HEX_EN
         ABS:     state_next = hex_reg ? WRITE : CONVERT;
`else
         ABS:     state_next = CONVERT;
`endif
         CONVERT: if (bcd_done) state_next = WRITE;
         WRITE:   if (col_reg == CW'(COLS-1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Character for the current column; k counts digits from the right edge.
   always_comb begin
      ndig = 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] != 4'd0) ndig = i + 1;
      end
      k         = COLS - 1 - int'(col_reg);
      dig       = 4'd0;
      char_next = SPACE;
      for (int i = 0; i < DIGITS; i++) begin
         if (k == i) dig = bcd[i*4 +: 4];
      end
      if (k < ndig) begin
         char_next = ZERO + {4'd0, dig};
      end else if ((k == ndig) && neg_reg) begin
         char_next = MINUS;
      end
`ifdef LCD_FMT_HEX_EN
      nib = 4'd0;
      for (int i = 0; i < HEX_DIGITS; i++) begin
         if (k == i) nib = data_reg[i*4 +: 4];
      end
      if (hex_reg) begin
         char_next = (k < HEX_DIGITS) ? hex_ascii(nib) : SPACE;
      end
`endif
   end

   // Character buffer: blanked on reset, one column of the target line per WRITE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int l = 0; l < LCD_LINES; l++) begin
            for (int c = 0; c < COLS; c++) begin
               buf_reg[l][c] <= SPACE;
            end
         end
      end else if (state_reg == WRITE) begin
         buf_reg[line_reg][col_reg] <= char_next;
      end
   end

   // Registered read port for the LCD driver; columns past the panel read as blank.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_char_reg <= SPACE;
      end else begin
         rd_char_reg <= (int'(rd_col) < COLS) ? buf_reg[rd_line][rd_col] : SPACE;
      end
   end

   assign rd_char = rd_char_reg;

endmodule

// File: tb/tb_lcd_num_formatter.sv
// Testbench for lcd_num_formatter: scoreboard of expected line texts,
// pushed on accept and popped on frame_upd, plus buffer readback.
// Define LCD_FMT_HEX_EN to also exercise the hex display path.
module tb_lcd_num_formatter;

   localparam int LAT_DEC = 34;
   localparam int LAT_HEX = 18;

   logic        clk      = 1'b0;
   logic        rst      = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data  = 16'd0;
   logic        in_line  = 1'b0;
   logic        hex_sel  = 1'b0;
   logic        rd_line  = 1'b0;
   logic [3:0]  rd_col   = 4'd0;
   logic [7:0]  rd_char;
   logic        in_ready;
   logic        busy;
   logic        frame_upd;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic         ln;
      logic [127:0] text;
   } exp_t;

   exp_t       sb_q [$];
   logic [7:0] model_buf [2][16];

   always #5 clk = ~clk;

   lcd_num_formatter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_line   (in_line),
`ifdef LCD_FMT_HEX_EN
      .in_hex    (hex_sel),
`endif
      .rd_line   (rd_line),
      .rd_col    (rd_col),
      .rd_char   (rd_char),
      .busy      (busy),
      .frame_upd (frame_upd)
   );

   // Reference text: right-justified decimal (signed) or 4-digit uppercase hex.
   function automatic logic [127:0] fmt_text(input logic [15:0] v, input logic hx);
      string        s;
      int           off;
      logic [127:0] t;
      if (hx) s = $sformatf("%04X", v);
      else    s = $sformatf("%0d", $signed(v));
      off = 16 - s.len();
      t   = '0;
      for (int i = 0; i < 16; i++) begin
         t[i*8 +: 8] = (i >= off) ? s[i-off] : 8'h20;
      end
      return t;
   endfunction

   task automatic blank_model();
      for (int l = 0; l < 2; l++)
         for (int c = 0; c < 16; c++)
            model_buf[l][c] = 8'h20;
      sb_q.delete();
   endtask

   task automatic push_exp(input logic [15:0] v, input logic ln, input logic hx);
      exp_t e;
      e.ln   = ln;
      e.text = fmt_text(v, hx);
      sb_q.push_back(e);
   endtask

   task automatic take_frame(input string name);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: frame_upd with no pending entry", name);
      end else begin
         e = sb_q.pop_front();
         for (int c = 0; c < 16; c++) model_buf[e.ln][c] = e.text[c*8 +: 8];
      end
   endtask

   task automatic check_buffer(input string name);
      for (int l = 0; l < 2; l++) begin
         for (int c = 0; c < 16; c++) begin
            rd_line = l[0];
            rd_col  = c[3:0];
            @(posedge clk); #1;
            checks++;
            if (rd_char !== model_buf[l][c]) begin
               errors++;
               $display("FAIL %s buf[%0d][%0d]: got 0x%02h required 0x%02h",
                        name, l, c, rd_char, model_buf[l][c]);
            end
         end
      end
   endtask

   // One transaction: wait for ready, accept, time frame_upd, check handshake.
   task automatic send(input logic [15:0] v, input logic ln, input logic hx,
                       input int lat, input string name);
      int k;
      bit ok_busy;
      ok_busy = 1'b1;
      k = 0;
      while (in_ready !== 1'b1 && k < 100) begin
         @(posedge clk); #1; k++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_wait: in_ready=%b required 1", name, in_ready);
      end
      in_data  = v;
      in_line  = ln;
      hex_sel  = hx;
      in_valid = 1'b1;
      push_exp(v, ln, hx);
      @(posedge clk); #1;
      in_valid = 1'b0;
      k = 1;
      while (frame_upd !== 1'b1 && k < lat + 5) begin
         if (busy !== 1'b1 || in_ready !== 1'b0) ok_busy = 1'b0;
         @(posedge clk); #1; k++;
      end
      checks++;
      if (!ok_busy) begin
         errors++;
         $display("FAIL %s busy: busy/in_ready wrong during conversion, required busy=1 in_ready=0", name);
      end
      checks++;
      if (frame_upd !== 1'b1) begin
         errors++;
         $display("FAIL %s frame_timeout: no frame_upd within %0d cycles, required at %0d", name, k, lat);
         void'(sb_q.pop_front());
      end else begin
         if (k != lat) begin
            errors++;
            $display("FAIL %s latency: frame_upd at cycle %0d required %0d", name, k, lat);
         end
         take_frame(name);
      end
      @(posedge clk); #1;
      checks++;
      if (frame_upd !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after_done: frame_upd=%b in_ready=%b required 0 1", name, frame_upd, in_ready);
      end
      $display("txn %s: data=0x%04h line=%0d hex=%0d frame at cycle %0d", name, v, ln, hx, k);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      blank_model();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || frame_upd !== 1'b0 || rd_char !== 8'h20) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b busy=%b frame_upd=%b rd_char=0x%02h required 1 0 0 0x20",
                  in_ready, busy, frame_upd, rd_char);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      check_buffer("reset");
   endtask

   task automatic test_zero();
      send(16'd0, 1'b0, 1'b0, LAT_DEC, "zero");
      check_buffer("zero");
   endtask

   task automatic test_min();
      send(16'h8000, 1'b1, 1'b0, LAT_DEC, "min_neg");
      check_buffer("min_neg");
   endtask

   task automatic test_back_to_back();
      send(16'd12345, 1'b0, 1'b0, LAT_DEC, "pos_12345");
      send(16'hFFF9, 1'b1, 1'b0, LAT_DEC, "neg_7");
      check_buffer("back_to_back");
   endtask

   task automatic test_hold_valid();
      int accepts;
      int frames;
      bit ok;
      accepts = 0;
      frames  = 0;
      ok      = 1'b1;
      in_data  = 16'd4321;
      in_line  = 1'b0;
      hex_sel  = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < 70; c++) begin
         if (in_ready === 1'b1) begin
            accepts++;
            push_exp(in_data, in_line, 1'b0);
         end
         if (busy === in_ready) ok = 1'b0;
         @(posedge clk); #1;
         if (frame_upd === 1'b1) begin
            frames++;
            take_frame("hold_valid");
         end
      end
      in_valid = 1'b0;
      checks++;
      if (accepts != 2) begin
         errors++;
         $display("FAIL hold_valid accepts: got %0d required 2", accepts);
      end
      checks++;
      if (frames != 2) begin
         errors++;
         $display("FAIL hold_valid frames: got %0d required 2", frames);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL hold_valid ready_vs_busy: in_ready not the inverse of busy");
      end
      $display("txn hold_valid: accepts=%0d frames=%0d", accepts, frames);
      check_buffer("hold_valid");
   endtask

   task automatic test_reset_mid();
      bit ok;
      ok = 1'b1;
      in_data  = 16'd999;
      in_line  = 1'b1;
      hex_sel  = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset precondition: busy=%b required 1", busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || frame_upd !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset state: in_ready=%b busy=%b frame_upd=%b required 1 0 0",
                  in_ready, busy, frame_upd);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      blank_model();
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (frame_upd !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL mid_reset frame_upd: pulse seen after reset, required none");
      end
      $display("txn mid_reset: aborted conversion of 999");
      check_buffer("mid_reset");
      send(16'hFE0C, 1'b0, 1'b0, LAT_DEC, "neg_500");
      check_buffer("after_mid_reset");
   endtask

`ifdef LCD_FMT_HEX_EN
   task automatic test_hex();
      send(16'hBEEF, 1'b0, 1'b1, LAT_HEX, "hex_beef");
      check_buffer("hex_beef");
   endtask
`endif

   initial begin
      test_reset();
      test_zero();
      test_min();
      test_back_to_back();
      test_hold_valid();
      test_reset_mid();
`ifdef LCD_FMT_HEX_EN
      test_hex();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lcd_num_formatter.md
Name: lcd_num_formatter

Overview:
Upstream feeder for the 2x16 text LCD driver. Accepts a signed binary result from the calculator datapath over a valid/ready handshake and converts it to decimal ASCII with a sequential double-dabble. Writes the text right-justified into a 2-line x 16-column character buffer. The LCD driver reads characters from the buffer by line/column while it scans the panel.

Parameters:
DATA_W, 16, width of signed input value (two's complement)
DIGITS, 5, max decimal digits of |value| (must cover 2^(DATA_W-1))
COLS, 16, characters per LCD line

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
in_valid  in  1  in_data/in_line valid
in_ready  out  1  formatter idle, can accept
in_data  in  DATA_W  signed value to display
in_line  in  1  target line: 0 = line1, 1 = line2
rd_line  in  1  read line select from LCD driver
rd_col  in  4  read column, 0 = leftmost
rd_char  out  8  ASCII at (rd_line, rd_col), registered
busy  out  1  conversion or buffer write in progress
frame_upd  out  1  one-cycle pulse: target line fully rewritten

Behaviour:
- Reset (rst=0, async): state IDLE; all 32 buffer entries = 0x20; rd_char=0x20; in_ready=1; busy=0; frame_upd=0.
- Handshake: accept on rising clk when in_valid && in_ready. in_ready = (state==IDLE). Latch in_data and in_line on accept. in_valid while busy: ignored, not queued; source must hold it.
- FSM:
  IDLE -> ABS on accept.
  ABS (1 cycle): neg = in_data[DATA_W-1]. mag = |in_data| in DATA_W+1 bits, so -2^(DATA_W-1) is exact. Clear BCD register.
  CONVERT (DATA_W cycles): double-dabble, one bit per cycle; add 3 to any nibble >=5 before shift. Then ndig = index of most significant nonzero digit + 1; minimum 1, so 0 -> "0".
  WRITE (COLS cycles): col c = 0..COLS-1, one column per cycle, k = COLS-1-c:
    k < ndig -> 0x30 + digit[k];
    k == ndig && neg -> 0x2D;
    else 0x20.
  DONE (1 cycle): frame_upd=1 -> IDLE.
- Latency: frame_upd high in cycle 1+DATA_W+COLS+1 (=34 default) after the accept edge; in_ready=1 the cycle after.
- busy = 1 in ABS, CONVERT, WRITE, DONE.
- Read port: rd_char registered from buffer (1-cycle latency). Reading the column being written in the same cycle returns the old value. The non-target line is never modified.
- Reset mid-operation: immediate return to reset state; buffer blanked; no frame_upd.
- rd_col >= COLS: rd_char = 0x20.

Optional Feature:
LCD_FMT_HEX_EN
- Defined: extra input port in_hex (1 bit), latched on accept. in_hex=1 skips CONVERT (ABS -> WRITE). Display is in_data unsigned as DATA_W/4 uppercase hex digits with leading zeros (0x30-0x39, 0x41-0x46), no sign, right-justified, remaining columns 0x20. Latency 1+COLS+1.
- Not defined: port absent, decimal only.

Decomposition:
- Package lcd_pkg: ASCII constants (SPACE 0x20, MINUS 0x2D, ZERO 0x30, ALPHA_A 0x41); FSM state encoding (IDLE, ABS, CONVERT, WRITE, DONE); COLS/LINES constants shared with the LCD driver.
- One sub-module: bin2bcd_seq. Sequential double-dabble with start/done, DATA_W+1 in, DIGITS*4 out. Instantiated by the formatter.

Test Plan:
- in_data=0, in_line=0 -> after 34 cycles frame_upd pulse; line1 = 15 spaces + "0"; line2 all 0x20.
- in_data=-32768 (0x8000), line 1 -> line2 = 10 spaces + "-32768"; line1 unchanged.
- 12345 to line0, then -7 to line1 -> line0 = 11 spaces + "12345", line1 = 14 spaces + "-7"; second accept only after in_ready returns.
- in_valid held high across busy -> exactly one accept per 35-cycle window; in_ready=0 during busy.
- rst=0 at cycle 10 of CONVERT -> buffer all 0x20, no frame_upd, in_ready=1 immediately; next value converts correctly.
- (LCD_FMT_HEX_EN) in_hex=1, in_data=0xBEEF -> 12 spaces + "BEEF", frame_upd 18 cycles after accept.
